dijkstra_weights_ram: RTL
=========================

// Module: dijkstra_weights_ram
// PURPOSE
//  Responder for the accelerator's weights-RAM read port: answers cs/addr with one PIPE_WIDTH-lane row per read.
//  Also owns the host load path: packs a stream of single weights into rows and writes them to the internal single-port array.
//  Sits between the host/loader and the dijkstra accelerator. Row r holds weights for vertices r*PIPE_WIDTH..r*PIPE_WIDTH+PIPE_WIDTH-1.
// PARAMETERS
//  VIRTEX_DWIDTH  16  signed weight width; negative value = no link
//  VIRTEX_AWIDTH  8   row address width; depth = 2**VIRTEX_AWIDTH rows
//  PIPE_WIDTH     4   lanes per row (power of 2, >=2)
// PORTS
//  clk               in   1                 clock
//  rst               in   1                 synchronous reset, active-high
//  ram_cs_i          in   1                 read request (accelerator weights_ram_cs)
//  ram_addr_i        in   VIRTEX_AWIDTH     read row address
//  ram_data_o        out  DWIDTH x PIPE     read row, lane i = vertex addr*PIPE_WIDTH+i
//  load_start_i      in   1                 start-of-load pulse
//  load_base_i       in   VIRTEX_AWIDTH     first row of the load, sampled with load_start_i
//  load_valid_i      in   1                 weight beat valid
//  load_ready_o      out  1                 beat accepted when valid&ready
//  load_data_i       in   VIRTEX_DWIDTH     weight
//  load_last_i       in   1                 final beat of the load
//  load_busy_o       out  1                 load in progress (LOAD or FLUSH)
//  load_done_o       out  1                 one-cycle pulse: load fully written
//  load_ovf_o        out  1                 sticky: row address wrapped during the load
//  rd_conflict_o     out  1                 one-cycle pulse: read dropped due to a row write
//  parity_err_o      out  1                 one-cycle pulse (DIJKSTRA_WRAM_PARITY_EN only)
// BEHAVIOUR
//  Reset: every output 0, state IDLE, lane counter 0. Array contents are not reset.
//  FSM IDLE -> LOAD on load_start_i. IDLE also ignores beats (ready=0).
//  LOAD -> FLUSH on an accepted last beat that leaves a partial row. LOAD -> IDLE directly when the last beat completes a row.
//  FLUSH -> IDLE after 1 cycle. load_start_i outside IDLE is ignored.
//  load_ready_o = 1 exactly in LOAD. Lane counter increments per accepted beat and wraps at PIPE_WIDTH.
//  Lanes 0..PIPE_WIDTH-2 are registered. The beat filling lane PIPE_WIDTH-1 is written combinationally with them in the same cycle.
//  Row write: at row address wr_row, which then increments modulo 2**VIRTEX_AWIDTH.
//  On an increment from all-ones to 0, load_ovf_o is set. It clears on the next accepted load_start_i.
//  FLUSH writes the partial row. Unfilled lanes are padded with NO_LINK = {1'b1,{DWIDTH-1{1'b0}}}.
//  load_done_o pulses the cycle after the final row write, i.e. in the IDLE cycle following it.
//  Read latency is 1: cs in cycle N -> ram_data_o updated at N+1. ram_data_o holds its last value when cs is low.
//  Single port: a write has priority. cs during a write cycle is dropped: ram_data_o holds and rd_conflict_o pulses at N+1.
//  Reset mid-load: the partial row is discarded (never written); FSM goes to IDLE, no done pulse.
//  Read and write of the same row in different cycles: the read returns the newly written data.
// CONFIGURATION
//  DIJKSTRA_WRAM_PARITY_EN defined:
//   - each lane stores an extra even-parity bit computed on write.
//   - each read checks all lanes; any mismatch pulses parity_err_o with the data (N+1).
//  Undefined:
//   - no parity storage; parity_err_o tied 0.
// STRUCTURE
//  dijkstra_pkg: VIRTEX_DWIDTH/AWIDTH, PIPE_WIDTH, NO_LINK constant, weight_t typedef, wram_state_e enum (IDLE/LOAD/FLUSH).
//  Sub-module dijkstra_sp_mem: plain single-port array, registered read, write-priority, width PIPE*(DWIDTH+PAR).
//  Top level holds the FSM, packer, address counter and flags.
// TESTING (PIPE_WIDTH=4, DWIDTH=16, AWIDTH=4)
//  1. start base=2; 8 beats 1..8, last on 8 -> rows 2,3 written; done pulses once; read row 3 -> {5,6,7,8} next cycle.
//  2. start base=1; 6 beats 10..15 -> row1={10,11,12,13}, row2={14,15,8000h,8000h}; FLUSH 1 cycle; then done.
//  3. cs=1 addr=0 in the cycle row 3 is written -> rd_conflict_o=1 next cycle; ram_data_o unchanged.
//  4. start base=15; 8 beats -> rows 15 and 0 written; load_ovf_o=1 until next start.
//  5. rst after 3 beats -> target row unchanged on readback; busy=0; ready=0; no done pulse.
//  6. PARITY_EN: backdoor-flip 1 bit of row 2 lane 1; read row 2 -> parity_err_o=1 next cycle; other rows -> 0.

Source files
------------

// File: rtl/dijkstra_pkg.sv
// dijkstra_pkg: shared widths, NO_LINK weight and load FSM states for the weights RAM
package dijkstra_pkg;
  localparam int VIRTEX_DWIDTH = 16;
  localparam int VIRTEX_AWIDTH = 8;
  localparam int PIPE_WIDTH = 4;
  typedef logic signed [VIRTEX_DWIDTH-1:0] weight_t;
  localparam weight_t NO_LINK = {1'b1, {(VIRTEX_DWIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} wram_state_e;
endpackage

// File: rtl/dijkstra_sp_mem.sv
// dijkstra_sp_mem: single-port row array with registered read; a write owns the port and the read output holds
module dijkstra_sp_mem #(
  parameter int AW = 8,
  parameter int W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q, rdata_d;
  always_comb rdata_d = (re && !we) ? mem[addr] : rdata_q;
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  always_ff @(posedge clk) rdata_q <= rst ? '0 : rdata_d;
  assign rdata_o = rdata_q;
endmodule

// File: rtl/dijkstra_weights_ram.sv
// dijkstra_weights_ram: weights-RAM read responder plus host loader packing single weights into rows.
// Optional per-lane even parity with DIJKSTRA_WRAM_PARITY_EN.
module dijkstra_weights_ram #(
  parameter int VIRTEX_DWIDTH = dijkstra_pkg::VIRTEX_DWIDTH,
  parameter int VIRTEX_AWIDTH = dijkstra_pkg::VIRTEX_AWIDTH,
  parameter int PIPE_WIDTH = dijkstra_pkg::PIPE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ram_cs_i,
  input  logic [VIRTEX_AWIDTH-1:0]            ram_addr_i,
  output logic [PIPE_WIDTH*VIRTEX_DWIDTH-1:0] ram_data_o,
  input  logic                                load_start_i,
  input  logic [VIRTEX_AWIDTH-1:0]            load_base_i,
  input  logic                                load_valid_i,
  output logic                                load_ready_o,
  input  logic [VIRTEX_DWIDTH-1:0]            load_data_i,
  input  logic                                load_last_i,
  output logic                                load_busy_o,
  output logic                                load_done_o,
  output logic                                load_ovf_o,
  output logic                                rd_conflict_o,
  output logic                                parity_err_o
);
  import dijkstra_pkg::*;
  localparam int DW = VIRTEX_DWIDTH;
  localparam int AW = VIRTEX_AWIDTH;
  localparam int P = PIPE_WIDTH;
  localparam int LW = $clog2(P);
  localparam int RW = P * DW;
`ifdef DIJKSTRA_WRAM_PARITY_EN
  localparam int MW = RW + P;
`else
  localparam int MW = RW;
`endif
  localparam logic [LW-1:0] LMAX = LW'(P - 1);
  localparam logic [DW-1:0] PAD = {1'b1, {(DW-1){1'b0}}};
  wram_state_e state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [(P-1)*DW-1:0] buf_q, buf_d;
  logic [AW-1:0] row_q, row_d;
  logic ovf_q, ovf_d, done_q, done_d, conflict_q, conflict_d;
  logic start, accept, we;
  logic [RW-1:0] wrow;
  logic [MW-1:0] wdata, rdata;
  always_comb begin
    start = (state_q == IDLE) && load_start_i;
    accept = (state_q == LOAD) && load_valid_i;
    we = (accept && lane_q == LMAX) || state_q == FLUSH;
    // lanes at or beyond the fill count only occur in FLUSH and get padded
    for (int i = 0; i < P - 1; i++) wrow[i*DW +: DW] = (i < int'(lane_q)) ? buf_q[i*DW +: DW] : PAD;
    wrow[RW-1 -: DW] = (state_q == LOAD) ? load_data_i : PAD;
    state_d = start ? LOAD : (state_q == FLUSH) ? IDLE : (accept && load_last_i) ? (we ? IDLE : FLUSH) : state_q;
    done_d = (state_q == FLUSH) || (accept && load_last_i && we);
    lane_d = (start || state_q == FLUSH) ? '0 : accept ? lane_q + 1'b1 : lane_q;
    buf_d = buf_q;
    if (accept && lane_q != LMAX) buf_d[int'(lane_q)*DW +: DW] = load_data_i;
    row_d = start ? load_base_i : we ? row_q + 1'b1 : row_q;
    ovf_d = start ? 1'b0 : ovf_q | (we && &row_q);
    conflict_d = ram_cs_i && we;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q <= '0;
      buf_q <= '0;
      row_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      buf_q <= buf_d;
      row_q <= row_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      conflict_q <= conflict_d;
    end
  end
`ifdef DIJKSTRA_WRAM_PARITY_EN
  logic [P-1:0] par_w, par_r;
  logic rd_ok_q, rd_ok_d;
  always_comb begin
    for (int i = 0; i < P; i++) begin
      par_w[i] = ^wrow[i*DW +: DW];
      par_r[i] = ^rdata[i*DW +: DW];
    end
    rd_ok_d = ram_cs_i && !we;
  end
  always_ff @(posedge clk) rd_ok_q <= rst ? 1'b0 : rd_ok_d;
  assign wdata = {par_w, wrow};
  assign parity_err_o = rd_ok_q && (par_r != rdata[RW +: P]);
`else
  assign wdata = wrow;
  assign parity_err_o = 1'b0;
`endif
  dijkstra_sp_mem #(.AW(AW), .W(MW)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(we && !rst),
    .re(ram_cs_i),
    .addr(we ? row_q : ram_addr_i),
    .wdata(wdata),
    .rdata_o(rdata)
  );
  assign ram_data_o = rdata[RW-1:0];
  assign load_ready_o = state_q == LOAD;
  assign load_busy_o = state_q != IDLE;
  assign load_done_o = done_q;
  assign load_ovf_o = ovf_q;
  assign rd_conflict_o = conflict_q;
endmodule
